// File: rtl/inst_rom_loader_pkg.sv
// Shared widths, constants and loader state encoding for the instruction ROM
// and its byte-stream boot loader.
package inst_rom_loader_pkg;

  localparam int InstBusW     = 32;
  localparam int InstAddrBusW = 32;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic [1:0]  ByteLast = 2'd3;
  localparam logic [1:0]  ByteInc  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } ld_state_e;

  // Streams arrive most-significant byte first, so each new byte enters at the bottom.
  function automatic logic [31:0] be_shift(input logic [23:0] acc, input logic [7:0] b);
    return {acc, b};
  endfunction

endpackage

// File: rtl/inst_rom_loader_mem.sv
// Instruction word array: one synchronous write port for the loader and one
// asynchronous read port so the CPU sees fetch data in the same cycle.
module inst_rom_mem
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int INST_W = InstBusW
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [INST_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [INST_W-1:0] rdata_o
);

  logic [INST_W-1:0] mem_q [2**ADDR_W];

  // Loader write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction-memory responder for the CPU fetch port plus a boot loader that
// fills the memory from a big-endian byte stream while holding the CPU in reset.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int INST_W = InstBusW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [INST_W-1:0] rom_data_o,
  input  logic              load_start_i,
  input  logic              load_valid_i,
  input  logic [7:0]        load_data_i,
  output logic              load_ready_o,
  output logic              cpu_rst_o,
  output logic              load_done_o,
  output logic              load_err_o,
  output logic [ADDR_W:0]   words_loaded_o
);

  localparam int              Depth    = 2**ADDR_W;
  localparam logic [31:0]     DepthW   = 32'(Depth);
  localparam logic [ADDR_W:0] CountMax = (ADDR_W+1)'(Depth);
  localparam logic [ADDR_W:0] WordInc  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] WordZero = {(ADDR_W+1){1'b0}};

  ld_state_e         state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept_s;
  logic [31:0]       assembled_s;
  logic [ADDR_W:0]   words_inc_s;
  logic              mem_we_s;
  logic [INST_W-1:0] mem_rdata_s;
  logic              addr_in_range_s;
  logic              addr_lsb_unused_s;

  assign accept_s          = load_valid_i & ready_q;
  assign assembled_s       = be_shift(shift_q, load_data_i);
  assign words_inc_s       = words_q + WordInc;
  assign mem_we_s          = (state_q == ST_DATA) && accept_s && (byte_cnt_q == ByteLast);
  assign addr_in_range_s   = (rom_addr_i[31:ADDR_W+2] == {(30-ADDR_W){1'b0}});
  assign addr_lsb_unused_s = ^rom_addr_i[1:0];

  inst_rom_mem #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we_s),
    .waddr_i (words_q[ADDR_W-1:0]),
    .wdata_i (assembled_s),
    .raddr_i (rom_addr_i[ADDR_W+1:2]),
    .rdata_o (mem_rdata_s)
  );

  // Zero-latency fetch: disabled or out-of-range requests read as zero.
  always_comb begin
    rom_data_o = ZeroWord;
    if (rom_ce_i && addr_in_range_s) begin
      rom_data_o = mem_rdata_s;
    end else begin
      rom_data_o = ZeroWord;
    end
  end

  // Loader next-state: header count, then word assembly and write-back.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    count_d    = count_q;
    words_d    = words_q;
    cpu_rst_d  = cpu_rst_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        cpu_rst_d = 1'b1;
        ready_d   = 1'b0;
        if (load_start_i) begin
          state_d    = ST_HDR;
          cpu_rst_d  = 1'b0;
          ready_d    = 1'b1;
          err_d      = 1'b0;
          words_d    = WordZero;
          byte_cnt_d = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (accept_s) begin
          byte_cnt_d = byte_cnt_q + ByteInc;
          shift_d    = assembled_s[23:0];
          if (byte_cnt_q != ByteLast) begin
            state_d = ST_HDR;
          end else if (assembled_s == ZeroWord) begin
            state_d = ST_DONE;
            count_d = WordZero;
            ready_d = 1'b0;
            done_d  = 1'b1;
          end else if (assembled_s > DepthW) begin
            // Oversized image: keep loading what fits, flag it, drop the rest.
            state_d = ST_DATA;
            count_d = CountMax;
            err_d   = 1'b1;
          end else begin
            state_d = ST_DATA;
            count_d = assembled_s[ADDR_W:0];
          end
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          byte_cnt_d = byte_cnt_q + ByteInc;
          shift_d    = assembled_s[23:0];
          if (byte_cnt_q != ByteLast) begin
            state_d = ST_DATA;
          end else if (words_inc_s == count_q) begin
            words_d = words_inc_s;
            state_d = ST_DONE;
            ready_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            words_d = words_inc_s;
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DONE: begin
        // CPU reset is released only on entry to IDLE, one cycle after the last write.
        state_d   = ST_IDLE;
        ready_d   = 1'b0;
        cpu_rst_d = 1'b1;
      end
      default: begin
        state_d   = ST_IDLE;
        ready_d   = 1'b0;
        cpu_rst_d = 1'b1;
      end
    endcase
  end

  // Loader state and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'h00_0000;
      count_q    <= WordZero;
      words_q    <= WordZero;
      cpu_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      count_q    <= count_d;
      words_q    <= words_d;
      cpu_rst_q  <= cpu_rst_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign load_ready_o   = ready_q;
  assign cpu_rst_o      = cpu_rst_q;
  assign load_done_o    = done_q;
  assign load_err_o     = err_q;
  assign words_loaded_o = words_q;

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Instruction-memory responder for the CPU fetch port. It answers rom_ce/rom_addr requests with 32-bit instruction words.
- It also contains a byte-stream boot loader that fills the memory.
- While a load runs, the CPU core is held in reset. It is released after the last word has been written.
- Sits beside the CPU top at SoC level: rom_addr_o/rom_ce_o from the CPU feed this block, and rom_data_o feeds the CPU's rom_data_i.

Parameters:
- ADDR_W, 10, word-address width; memory depth = 2**ADDR_W 32-bit words.
- INST_W, 32, instruction word width. Fixed by the CPU; do not override.

Ports:
- clk  in  1  system clock, the CPU's clock.
- rst  in  1  synchronous, active-low reset.
- rom_ce_i  in  1  fetch enable from CPU.
- rom_addr_i  in  32  byte address from CPU pc.
- rom_data_o  out  32  instruction word to CPU.
- load_start_i  in  1  one-cycle pulse; starts a load. Ignored unless state is IDLE.
- load_valid_i  in  1  byte-stream valid.
- load_data_i  in  8  byte-stream data.
- load_ready_o  out  1  byte-stream ready; a byte is accepted when valid && ready at the clock edge.
- cpu_rst_o  out  1  active-low reset to the CPU core; 0 holds the CPU in reset.
- load_done_o  out  1  one-cycle pulse when a load completes.
- load_err_o  out  1  sticky; set when the header count exceeds depth. Cleared by the next load_start_i or by rst.
- words_loaded_o  out  ADDR_W+1  number of words written by the last or current load.

Behaviour:
- Fetch path, combinational read:
  - rom_data_o = mem[rom_addr_i[ADDR_W+1:2]] when rom_ce_i=1, otherwise 32'h0.
  - rom_addr_i[1:0] is ignored.
  - If rom_addr_i[31:ADDR_W+2] is nonzero, rom_data_o = 0.
  - Zero-latency read is required: the CPU latches rom_data in the same edge as pc.
- Reset (rst=0 at an edge):
  - state=IDLE, cpu_rst_o=1 (CPU runs the existing image), load_ready_o=0, load_done_o=0, load_err_o=0, words_loaded_o=0, byte counter=0.
  - Memory contents are not cleared.
- FSM states IDLE, HDR, DATA, DONE:
  - IDLE: cpu_rst_o=1, load_ready_o=0. On load_start_i: go to HDR, set cpu_rst_o=0 and load_ready_o=1 from the next cycle, clear load_err_o and words_loaded_o.
  - HDR: accept 4 bytes, big-endian (first byte is bits 31:24), into count N.
    - On the 4th accepted byte: if N==0, go to DONE.
    - If N > 2**ADDR_W, set load_err_o and clamp N to 2**ADDR_W.
    - Otherwise go to DATA.
  - DATA: accept bytes into a big-endian shift register.
    - On every 4th byte, write the assembled word to mem[words_loaded_o] in that same edge and increment words_loaded_o.
    - When words_loaded_o reaches N, go to DONE.
    - Bytes arriving after a clamp are not accepted: load_ready_o=0 in DONE.
  - DONE: lasts exactly one cycle. load_done_o=1, load_ready_o=0, cpu_rst_o stays 0. Next state is IDLE, where cpu_rst_o returns to 1.
  - The CPU therefore sees at least one cycle of reset after the last write, so it restarts from pc 0 with the new image.
- load_valid_i=0 stalls the HDR and DATA states indefinitely; there is no timeout.
- load_start_i while not in IDLE is ignored.
- Byte counter (2 bits) wraps 3→0 per word. Partial words are never written.
- Simultaneous fetch and write to the same word (cannot occur while the CPU is held in reset; only a bench forcing it): rom_data_o shows the old word until the edge, the new word after it.
- rst low mid-load: the FSM aborts to IDLE and cpu_rst_o=1. Words already written stay written. The CPU runs the partial image; this is acceptable.

Decomposition:
- Shared package/defines: ZeroWord, InstBus/InstAddrBus widths already used by the CPU, loader state encodings (IDLE=2'd0, HDR=2'd1, DATA=2'd2, DONE=2'd3).
- One natural sub-module: inst_rom_mem, the 2**ADDR_W x 32 array with one synchronous write port and one asynchronous read port.
- The FSM and byte assembler stay in the top.

Test Plan:
- Fetch after rst: preload mem[3]=32'h3401_1100. rom_ce_i=1, rom_addr_i=32'hC → rom_data_o=32'h3401_1100. rom_ce_i=0 → rom_data_o=0. rom_addr_i=32'hD → same word.
- Normal load: pulse load_start_i; stream 00 00 00 02, 12 34 56 78, 9A BC DE F0 with valid held high.
  - Required: cpu_rst_o=0 from the cycle after start.
  - Required: mem[0]=32'h1234_5678, mem[1]=32'h9ABC_DEF0.
  - Required: one load_done_o pulse, words_loaded_o=2, then cpu_rst_o=1.
- Backpressure gaps: same stream with load_valid_i toggling 1,0,0,1 between bytes → identical memory contents. The FSM remains in its current state during the gaps.
- Zero-length load: header 00 00 00 00 → DONE on the cycle after the 4th byte; no memory write; words_loaded_o=0.
- Over-length header: ADDR_W=2, header 00 00 00 09 → load_err_o=1, exactly 4 words written, load_ready_o=0 after the 16th data byte.
- Reset mid-load: rst=0 after 6 data bytes → state IDLE, cpu_rst_o=1, mem[0] written, mem[1] unchanged, load_err_o=0.
